ecc_field_alu: RTL and testbench

- Sequential, width-parametrised GF(p) arithmetic unit for the ECC scalar-multiplication datapath.
- Computes modular add, subtract, multiply and inverse under a start/done handshake.
- Replaces the fixed 4-bit field logic inside the current top; the point-add/double controller issues one field operation at a time.
- Generalised in operand width, and adds inversion and error reporting.

---
 rtl/ecc_pkg.sv | 26 ++
 rtl/ecc_mod_addsub.sv | 30 +++
 rtl/ecc_field_alu.sv | 178 +++++++++++++++++
 tb/tb_ecc_field_alu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the GF(p) field ALU: op codes, FSM states, iteration bound.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_OP_ADD = 2'd0,
        ECC_OP_SUB = 2'd1,
        ECC_OP_MUL = 2'd2,
        ECC_OP_INV = 2'd3
    } ecc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDSUB,
        ST_MUL,
        ST_INV,
        ST_DONE
    } ecc_state_e;

    // Binary extended Euclid needs at most ECC_ITER_FACTOR*W steps for a prime modulus.
    localparam int unsigned ECC_ITER_FACTOR = 4;

    function automatic int unsigned ecc_iter_bound(input int unsigned w);
        return ECC_ITER_FACTOR * w;
    endfunction

endpackage

// File: rtl/ecc_mod_addsub.sv
// Combinational modular add/subtract for operands already reduced below p.
module ecc_mod_addsub #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    input  logic         sub,
    output logic [W-1:0] r_c
);

    logic [W:0] sum_c;
    logic [W:0] diff_c;
    logic [W:0] red_c;
    logic [W:0] fix_c;

    // One conditional correction brings the W+1-bit intermediate back into [0, p-1].
    always_comb begin
        sum_c  = {1'b0, a} + {1'b0, b};
        diff_c = {1'b0, a} - {1'b0, b};
        red_c  = sum_c - {1'b0, p};
        fix_c  = diff_c + {1'b0, p};
        if (sub) begin
            r_c = diff_c[W] ? fix_c[W-1:0] : diff_c[W-1:0];
        end else begin
            r_c = (sum_c >= {1'b0, p}) ? red_c[W-1:0] : sum_c[W-1:0];
        end
    end

endmodule

// File: rtl/ecc_field_alu.sv
// Sequential GF(p) ALU: add, sub, interleaved multiply and binary-Euclid inverse.
// Optional operand range check enabled by defining ECC_FALU_RANGE_CHECK_EN.
module ecc_field_alu
    import ecc_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = $clog2(4*W) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_p,
    output logic [W-1:0] o_result,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    localparam logic [CNT_W-1:0] ITER_MAX  = CNT_W'(ecc_iter_bound(W));
    localparam logic [CNT_W-1:0] MUL_STEPS = CNT_W'(W);

    ecc_state_e       state_q;
    logic             sub_q;
    logic             fault_q;
    logic [W-1:0]     a_q, b_q, p_q;
    logic [W-1:0]     u_q, v_q, x1_q, x2_q;
    logic [CNT_W-1:0] cnt_q;

    logic             range_fault_c;
    logic             u_ge_v_c;
    logic [W-1:0]     xl_c, xr_c;
    logic [W-1:0]     addsub_c, dbl_c, acc_c, xsub_c;

    // x/2 mod p for odd p: odd x is made even by adding p first.
    function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[W:1];
    endfunction

    // Operand range fault, only meaningful when the check is built in.
    always_comb begin
        range_fault_c = 1'b0;
`ifdef ECC_FALU_RANGE_CHECK_EN
        range_fault_c = (i_a >= i_p) || ((i_op != ECC_OP_INV) && (i_b >= i_p)) || !i_p[0];
`endif
    end

    // Subtract step picks which of u/v shrinks and the matching x difference.
    always_comb begin
        u_ge_v_c = (u_q >= v_q);
        xl_c     = u_ge_v_c ? x1_q : x2_q;
        xr_c     = u_ge_v_c ? x2_q : x1_q;
    end

    ecc_mod_addsub #(.W(W)) u_addsub (.a(a_q),  .b(b_q),  .p(p_q), .sub(sub_q), .r_c(addsub_c));
    ecc_mod_addsub #(.W(W)) u_dbl    (.a(x1_q), .b(x1_q), .p(p_q), .sub(1'b0),  .r_c(dbl_c));
    ecc_mod_addsub #(.W(W)) u_acc    (.a(dbl_c), .b(a_q), .p(p_q), .sub(1'b0),  .r_c(acc_c));
    ecc_mod_addsub #(.W(W)) u_xsub   (.a(xl_c), .b(xr_c), .p(p_q), .sub(1'b1),  .r_c(xsub_c));

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            sub_q    <= 1'b0;
            fault_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            cnt_q    <= '0;
            o_result <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        p_q     <= i_p;
                        sub_q   <= (i_op == ECC_OP_SUB);
                        fault_q <= range_fault_c;
                        u_q     <= i_a;
                        v_q     <= i_p;
                        x1_q    <= (i_op == ECC_OP_INV) ? W'(1) : '0;
                        x2_q    <= '0;
                        cnt_q   <= '0;
                        o_busy  <= 1'b1;
                        o_err   <= 1'b0;
                        if (range_fault_c || (i_op == ECC_OP_ADD) || (i_op == ECC_OP_SUB)) begin
                            state_q <= ST_ADDSUB;
                        end else if (i_op == ECC_OP_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            state_q <= ST_INV;
                        end
                    end
                end
                ST_ADDSUB: begin
                    o_result <= fault_q ? '0 : addsub_c;
                    o_err    <= fault_q;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_MUL: begin
                    if (cnt_q == MUL_STEPS) begin
                        o_result <= x1_q;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        x1_q  <= b_q[W-1] ? acc_c : dbl_c;
                        b_q   <= b_q << 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_INV: begin
                    if ((cnt_q == '0) && (u_q == '0)) begin
                        o_result <= '0;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (u_q == W'(1)) begin
                        o_result <= x1_q;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (v_q == W'(1)) begin
                        o_result <= x2_q;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (cnt_q > ITER_MAX) begin
                        // Non-prime modulus never converges; give up with an error.
                        o_result <= '0;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!u_q[0]) begin
                            u_q  <= u_q >> 1;
                            x1_q <= halve_mod(x1_q, p_q);
                        end else if (!v_q[0]) begin
                            v_q  <= v_q >> 1;
                            x2_q <= halve_mod(x2_q, p_q);
                        end else if (u_ge_v_c) begin
                            u_q  <= u_q - v_q;
                            x1_q <= xsub_c;
                        end else begin
                            v_q  <= v_q - u_q;
                            x2_q <= xsub_c;
                        end
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_field_alu.sv
// Self-checking bench for ecc_field_alu at W=4 and W=32 against a modular-arithmetic model.
module tb_ecc_field_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start32;
    logic [1:0]  op;
    logic [31:0] a, b, p;
    logic [3:0]  res4;
    logic        busy4, done4, err4;
    logic [31:0] res32;
    logic        busy32, done32, err32;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          pend[2];
    logic [31:0] er[2];
    bit          ee[2];
    int          elat[2];
    int          acyc[2];
    int          ndone[2];
    int          wid[2] = '{4, 32};

    longint unsigned pl32[6] = '{64'hFFFFFFFB, 64'h7FFFFFFF, 64'd1000000007,
                                 64'd998244353, 64'd65521, 64'd251};
    longint unsigned pl4[5]  = '{64'd3, 64'd5, 64'd7, 64'd11, 64'd13};

    localparam longint unsigned PBIG = 64'hFFFFFFFB;
`ifdef ECC_FALU_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ecc_field_alu #(.W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_op(op),
        .i_a(a[3:0]), .i_b(b[3:0]), .i_p(p[3:0]),
        .o_result(res4), .o_busy(busy4), .o_done(done4), .o_err(err4));

    ecc_field_alu #(.W(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_op(op),
        .i_a(a), .i_b(b), .i_p(p),
        .o_result(res32), .o_busy(busy32), .o_done(done32), .o_err(err32));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic longint unsigned powmod(input longint unsigned x, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r = 1, bs = x % m, k = e;
        while (k != 0) begin
            if (k[0]) r = (r * bs) % m;
            bs = (bs * bs) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    // Field semantics: plain integer arithmetic reduced mod m; inverse by Fermat.
    function automatic longint unsigned ref_op(input int o, input longint unsigned x,
                                               input longint unsigned y, input longint unsigned m);
        case (o)
            0: return (x + y) % m;
            1: return (x + m - y) % m;
            2: return (x * y) % m;
            default: return (x == 0) ? 0 : powmod(x, m - 2, m);
        endcase
    endfunction

    // Expected result, error flag and done latency (0 = data-dependent inverse).
    task automatic model(input int o, input longint unsigned x, input longint unsigned y,
                         input longint unsigned m, input int w,
                         output longint unsigned r, output bit e, output int l);
        r = ref_op(o, x, y, m);
        e = (o == 3) && (x == 0);
        l = (o == 2) ? w + 1 : ((o == 3) && (x != 0)) ? 0 : 1;
`ifdef ECC_FALU_RANGE_CHECK_EN
        if ((x >= m) || ((o != 3) && (y >= m)) || (m % 2 == 0)) begin
            r = 0; e = 1'b1; l = 1;
        end
`endif
    endtask

    task automatic cmp_one(input int i, input logic d, input logic bs, input logic e,
                           input logic [31:0] r);
        int el;
        if (d === 1'b1) ndone[i]++;
        if (pend[i]) begin
            el = cyc - acyc[i];
            if (d === 1'b1) begin
                if (elat[i] != 0) chk($sformatf("latency[%0d]", i), el, elat[i]);
                else chk($sformatf("inv_bound[%0d] el=%0d", i, el), el <= 4 * wid[i] + 1, 1);
                chk($sformatf("result[%0d]", i), r, er[i]);
                chk($sformatf("err[%0d]", i), e, ee[i]);
                chk($sformatf("busy_at_done[%0d]", i), bs, 0);
                pend[i] = 1'b0;
            end else begin
                chk($sformatf("busy[%0d]", i), bs, 1);
                if ((elat[i] != 0 && el >= elat[i]) || (elat[i] == 0 && el > 4 * wid[i] + 2)) begin
                    chk($sformatf("done_missing[%0d]", i), d, 1);
                    pend[i] = 1'b0;
                end
            end
        end else begin
            chk($sformatf("idle_done[%0d]", i), d, 0);
            chk($sformatf("idle_busy[%0d]", i), bs, 0);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp_one(0, done4, busy4, err4, 32'(res4));
                cmp_one(1, done32, busy32, err32, res32);
            end
        end
    endtask

    task automatic accept(input int i, input logic [1:0] o, input longint unsigned xa,
                          input longint unsigned xb, input longint unsigned xp);
        longint unsigned r;
        bit e;
        int l;
        model(int'(o), xa, xb, xp, wid[i], r, e, l);
        @(negedge clk);
        op = o; a = 32'(xa); b = 32'(xb); p = 32'(xp);
        if (i == 0) start4 = 1'b1; else start32 = 1'b1;
        @(posedge clk);
        #1;
        pend[i] = 1'b1; acyc[i] = cyc; er[i] = 32'(r); ee[i] = e; elat[i] = l;
    endtask

    task automatic issue(input int i, input logic [1:0] o, input longint unsigned xa,
                         input longint unsigned xb, input longint unsigned xp, input bit hold);
        int guard = 0;
        accept(i, o, xa, xb, xp);
        if (!hold) begin start4 = 1'b0; start32 = 1'b0; end
        while (pend[i] && guard < 400) begin
            @(negedge clk);
            guard++;
            if (hold) begin a = $urandom; b = $urandom; p = $urandom; op = 2'($urandom); end
        end
        start4 = 1'b0; start32 = 1'b0;
        if (pend[i]) begin
            total++; bad++;
            $display("FAIL done_timeout[%0d]: no o_done after %0d cycles, o_done required", i, guard);
            pend[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        longint unsigned xp, xa, xb;
        int i, o, n0;
        rst_n = 1'b0; start4 = 1'b0; start32 = 1'b0; op = '0; a = '0; b = '0; p = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res4", res4, 0);    chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);  chk("rst_err4", err4, 0);
        chk("rst_res32", res32, 0);  chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0); chk("rst_err32", err32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            compare_loop();
        join_none

        // Hand-computed values pin the model.
        chk("pin_add", ref_op(0, 7, 9, 11), 5);
        chk("pin_sub", ref_op(1, 3, 8, 11), 6);
        chk("pin_mul", ref_op(2, 7, 8, 11), 1);
        chk("pin_inv3", ref_op(3, 3, 0, 11), 4);
        chk("pin_inv10", ref_op(3, 10, 0, 11), 10);
        chk("pin_inv2big", ref_op(3, 2, 0, PBIG), 64'h7FFFFFFE);
        chk("pin_mulbig", ref_op(2, PBIG - 1, PBIG - 1, PBIG), 1);
        chk("pin_addbig", ref_op(0, PBIG - 1, PBIG - 1, PBIG), 64'hFFFFFFF9);

        // Directed field operations.
        issue(0, 2'd0, 7, 9, 11, 0);   chk("lit_add", res4, 5);
        issue(0, 2'd1, 3, 8, 11, 0);   chk("lit_sub", res4, 6);
        issue(0, 2'd1, 5, 5, 11, 0);   chk("lit_sub0", res4, 0);
        issue(0, 2'd2, 7, 8, 11, 0);   chk("lit_mul", res4, 1);
        issue(0, 2'd3, 3, 0, 11, 0);   chk("lit_inv3", res4, 4);
        issue(0, 2'd3, 1, 0, 11, 0);   chk("lit_inv1", res4, 1);
        issue(0, 2'd3, 10, 0, 11, 0);  chk("lit_inv10", res4, 10);
        issue(0, 2'd3, 0, 0, 11, 0);
        chk("lit_inv0_res", res4, 0);  chk("lit_inv0_err", err4, 1);
        issue(1, 2'd2, PBIG - 1, PBIG - 1, PBIG, 0); chk("lit_mulbig", res32, 1);
        issue(1, 2'd3, 2, 0, PBIG, 0);               chk("lit_inv2big", res32, 32'h7FFFFFFE);
        issue(1, 2'd0, PBIG - 1, PBIG - 1, PBIG, 0); chk("lit_addbig", res32, 32'hFFFFFFF9);

        // Out-of-range operand: faulted only when the range check is built in.
        issue(0, 2'd0, 12, 1, 11, 0);
        chk("range_err", err4, RC);
        chk("range_res", res4, RC ? 0 : 2);

        // Start held high and inputs scrambled during a multiply.
        n0 = ndone[1];
        issue(1, 2'd2, 64'h12345678, 64'h9ABCDEF0 % PBIG, PBIG, 1);
        chk("hold_one_done", ndone[1] - n0, 1);
        chk("hold_err_cleared", err32, 0);

        // Asynchronous reset in the middle of a multiply.
        accept(1, 2'd2, 64'hDEADBEEF, 64'hCAFEF00D, PBIG);
        start32 = 1'b0;
        n0 = ndone[1];
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        pend[1] = 1'b0;
        #1;
        chk("mid_rst_res", res32, 0);   chk("mid_rst_busy", busy32, 0);
        chk("mid_rst_done", done32, 0); chk("mid_rst_err", err32, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_done", ndone[1] - n0, 0);
        issue(1, 2'd0, 3, 5, PBIG, 0);
        chk("post_rst_add", res32, 8);

        // Random sweep against the model.
        for (int k = 0; k < 1000; k++) begin
            i  = (k % 4 == 0) ? 0 : 1;
            xp = (i == 0) ? pl4[$urandom_range(4)] : pl32[$urandom_range(5)];
            xa = $urandom; xa = xa % xp;
            xb = $urandom; xb = xb % xp;
            if ($urandom_range(15) == 0) xa = 0;
            if ($urandom_range(15) == 0) xa = xp - 1;
            if ($urandom_range(15) == 0) xb = xp - 1;
            o = $urandom_range(3);
            issue(i, 2'(o), xa, xb, xp, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
